// File: rtl/flash_prog_seq.sv
// Flash program/erase command sequencer: issues the JEDEC unlock write
// sequence, then polls DQ6 toggle status until it settles or times out.
module flash_prog_seq #(
    parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
    input  logic        m2,
    input  logic        reset_pin,
    input  logic        req,
    input  logic [1:0]  cmd,
    input  logic [19:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  flash_bs,
    output logic [11:0] flash_addr,
    output logic [7:0]  flash_dout,
    input  logic [7:0]  flash_din,
    output logic        flash_ce,
    output logic        flash_oe_n,
    output logic        flash_we_n
);

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_PULSE, W_HOLD, P_OE, P_SAMPLE, DONE
    } state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_cmd;
    logic [19:0] r_addr;
    logic [7:0]  r_wdata;
    logic [2:0]  r_step;
    logic [15:0] r_poll;
    logic        r_prev6, r_have, r_rst_wr, r_err;

    logic        w_illegal, w_accept, w_last, w_complete, w_poll_max;
    logic [7:0]  w_wbs, w_wdat;
    logic [11:0] w_wadr;
    logic        w_unused_din;

    assign w_unused_din = ^{flash_din[7], flash_din[5:0]};
    assign w_illegal    = (cmd == 2'b11);
    // DONE also accepts so that a held req runs back-to-back with one DONE cycle
    assign w_accept     = req && !w_illegal && (r_state == IDLE || r_state == DONE);
    assign w_last       = (r_step == ((r_cmd == 2'b00) ? 3'd3 : 3'd5));
    assign w_complete   = r_have && (flash_din[6] == r_prev6);
    assign w_poll_max   = ({1'b0, r_poll} + 17'd1) >= {1'b0, POLL_LIMIT};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = W_SETUP;
                      else if (req) w_next = DONE;
            W_SETUP:  w_next = W_PULSE;
            W_PULSE:  w_next = W_HOLD;
            W_HOLD:   if (r_rst_wr) w_next = DONE;
                      else if (w_last) w_next = P_OE;
                      else w_next = W_SETUP;
            P_OE:     w_next = P_SAMPLE;
            P_SAMPLE: if (w_complete) w_next = DONE;
                      else if (w_poll_max) w_next = W_SETUP;
                      else w_next = P_OE;
            DONE:     w_next = w_accept ? W_SETUP : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(negedge m2 or negedge reset_pin) begin
        if (!reset_pin) begin
            r_state  <= IDLE;
            r_cmd    <= 2'b00;
            r_addr   <= 20'h0;
            r_wdata  <= 8'h00;
            r_step   <= 3'd0;
            r_poll   <= 16'h0;
            r_prev6  <= 1'b0;
            r_have   <= 1'b0;
            r_rst_wr <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cmd    <= cmd;
                r_addr   <= addr;
                r_wdata  <= wdata;
                r_err    <= 1'b0;
                r_step   <= 3'd0;
                r_poll   <= 16'h0;
                r_have   <= 1'b0;
                r_rst_wr <= 1'b0;
            end else if (r_state == IDLE && req) begin
                r_err <= 1'b1;
            end
            case (r_state)
                W_HOLD: begin
                    if (r_rst_wr) r_err <= 1'b1;
                    else if (!w_last) r_step <= r_step + 3'd1;
                end
                P_SAMPLE: begin
                    r_prev6 <= flash_din[6];
                    r_have  <= 1'b1;
                    r_poll  <= r_poll + 16'd1;
                    if (!w_complete && w_poll_max) r_rst_wr <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bus write table indexed by step; the timeout reset write overrides it
    always_comb begin
        w_wbs  = 8'h05;
        w_wadr = 12'h555;
        w_wdat = 8'h00;
        if (r_rst_wr) begin
            w_wdat = 8'hF0;
        end else begin
            case (r_step)
                3'd0: w_wdat = 8'hAA;
                3'd1: begin w_wbs = 8'h02; w_wadr = 12'hAAA; w_wdat = 8'h55; end
                3'd2: w_wdat = (r_cmd == 2'b00) ? 8'hA0 : 8'h80;
                3'd3: if (r_cmd == 2'b00) begin
                          w_wbs = r_addr[19:12]; w_wadr = r_addr[11:0]; w_wdat = r_wdata;
                      end else begin
                          w_wdat = 8'hAA;
                      end
                3'd4: begin w_wbs = 8'h02; w_wadr = 12'hAAA; w_wdat = 8'h55; end
                3'd5: if (r_cmd == 2'b01) begin
                          w_wbs = r_addr[19:12]; w_wadr = 12'h000; w_wdat = 8'h30;
                      end else begin
                          w_wdat = 8'h10;
                      end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy       = (r_state != IDLE);
        done       = (r_state == DONE);
        err        = r_err;
        flash_ce   = 1'b0;
        flash_oe_n = 1'b1;
        flash_we_n = 1'b1;
        flash_bs   = 8'h00;
        flash_addr = 12'h000;
        flash_dout = 8'h00;
        case (r_state)
            W_SETUP, W_PULSE, W_HOLD: begin
                flash_ce   = 1'b1;
                flash_we_n = (r_state != W_PULSE);
                flash_bs   = w_wbs;
                flash_addr = w_wadr;
                flash_dout = w_wdat;
            end
            P_OE, P_SAMPLE: begin
                flash_ce   = 1'b1;
                flash_oe_n = 1'b0;
                flash_bs   = r_addr[19:12];
                flash_addr = r_addr[11:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_flash_prog_seq.sv
// Directed bench for flash_prog_seq: a cycle table for program/illegal,
// plus erase, timeout, mid-op reset and back-to-back sequences.
module tb_flash_prog_seq;

    typedef struct {
        logic        rq;
        logic [1:0]  c;
        logic [5:0]  fl;   // {busy,done,err,ce,oe_n,we_n}
        logic [7:0]  b;
        logic [11:0] a;
        logic [7:0]  d;
    } vec_t;

    logic        m2, reset_pin, req;
    logic [1:0]  cmd;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        bsy[2], dn[2], er[2], ce[2], oen[2], wen[2];
    logic [7:0]  bs[2], dout[2], din[2];
    logic [11:0] fa[2];

    int total = 0, bad = 0;
    int mode = 0;
    int pc[2];
    logic viol = 1'b0;

    logic [27:0] wq[2][$];
    int          lat[2];
    logic        erv[2], ceseen[2];

    flash_prog_seq #(.POLL_LIMIT(16'd16)) u_dut (
        .m2(m2), .reset_pin(reset_pin), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .busy(bsy[0]), .done(dn[0]), .err(er[0]), .flash_bs(bs[0]), .flash_addr(fa[0]),
        .flash_dout(dout[0]), .flash_din(din[0]), .flash_ce(ce[0]), .flash_oe_n(oen[0]),
        .flash_we_n(wen[0]));

    flash_prog_seq #(.POLL_LIMIT(16'd4)) u_to (
        .m2(m2), .reset_pin(reset_pin), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .busy(bsy[1]), .done(dn[1]), .err(er[1]), .flash_bs(bs[1]), .flash_addr(fa[1]),
        .flash_dout(dout[1]), .flash_din(din[1]), .flash_ce(ce[1]), .flash_oe_n(oen[1]),
        .flash_we_n(wen[1]));

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    // Flash status model: sample index n counts polls within the current busy period
    always @(posedge m2) begin
        int n0, n1;
        for (int j = 0; j < 2; j++) pc[j] = oen[j] ? 0 : pc[j] + 1;
        n0 = (pc[0] + 1) / 2;
        n1 = (pc[1] + 1) / 2;
        din[0] = 8'h00;
        din[1] = 8'h00;
        if (mode == 1) din[0][6] = (n0 <= 6) ? n0[0] : 1'b0;
        else           din[0][6] = 1'b1;
        din[1][6] = n1[0];
        for (int j = 0; j < 2; j++) if (!oen[j] && !wen[j]) viol = 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bsy[0] || bsy[1]) && n < 200) begin @(posedge m2); n++; end
        @(posedge m2);
    endtask

    task automatic run_op(input logic [1:0] c, input logic [19:0] a, input logic [7:0] d);
        for (int j = 0; j < 2; j++) begin
            wq[j].delete(); lat[j] = 0; erv[j] = 1'b0; ceseen[j] = 1'b0;
        end
        wait_idle();
        req = 1'b1; cmd = c; addr = a; wdata = d;
        for (int cyc = 1; cyc <= 200 && (lat[0] == 0 || lat[1] == 0); cyc++) begin
            @(posedge m2);
            req = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (!wen[j]) wq[j].push_back({bs[j], fa[j], dout[j]});
                if (ce[j]) ceseen[j] = 1'b1;
                if (dn[j] && lat[j] == 0) begin lat[j] = cyc; erv[j] = er[j]; end
            end
        end
    endtask

    task automatic chk_wr(input int j, input string nm, input int idx, input logic [27:0] exp);
        logic [27:0] v = 28'hFFFFFFF;
        if (idx < wq[j].size()) v = wq[j][idx];
        chk($sformatf("%s[%0d]", nm, idx), {36'h0, v}, {36'h0, exp});
    endtask

    vec_t        tbl[22];
    logic [27:0] pwr[4];
    logic [27:0] ewr[6];

    function automatic vec_t mk(logic rq, logic [1:0] c, logic [5:0] fl,
                                logic [7:0] b, logic [11:0] a, logic [7:0] d);
        vec_t v;
        v.rq = rq; v.c = c; v.fl = fl; v.b = b; v.a = a; v.d = d;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int np, c1, c2;
        logic sawdone;
        logic [33:0] act;
        pwr[0] = {8'h05, 12'h555, 8'hAA}; pwr[1] = {8'h02, 12'hAAA, 8'h55};
        pwr[2] = {8'h05, 12'h555, 8'hA0}; pwr[3] = {8'h34, 12'h123, 8'h5A};
        ewr[0] = pwr[0]; ewr[1] = pwr[1]; ewr[2] = {8'h05, 12'h555, 8'h80};
        ewr[3] = pwr[0]; ewr[4] = pwr[1]; ewr[5] = {8'h7F, 12'h000, 8'h30};

        tbl[0] = mk(1'b1, 2'b00, 6'b000011, 8'h00, 12'h000, 8'h00);
        for (int w = 0; w < 4; w++)
            for (int p = 0; p < 3; p++)
                tbl[1 + 3*w + p] = mk(1'b0, 2'b00, (p == 1) ? 6'b100110 : 6'b100111,
                                      pwr[w][27:20], pwr[w][19:8], pwr[w][7:0]);
        for (int i = 13; i <= 16; i++) tbl[i] = mk(1'b0, 2'b00, 6'b100101, 8'h34, 12'h123, 8'h00);
        tbl[17] = mk(1'b0, 2'b00, 6'b110011, 8'h00, 12'h000, 8'h00);
        tbl[18] = mk(1'b1, 2'b11, 6'b000011, 8'h00, 12'h000, 8'h00);
        tbl[19] = mk(1'b0, 2'b00, 6'b111011, 8'h00, 12'h000, 8'h00);
        tbl[20] = mk(1'b0, 2'b00, 6'b001011, 8'h00, 12'h000, 8'h00);
        tbl[21] = mk(1'b0, 2'b00, 6'b001011, 8'h00, 12'h000, 8'h00);

        reset_pin = 1'b1; req = 1'b0; cmd = 2'b00; addr = 20'h0; wdata = 8'h00;
        #2 reset_pin = 1'b0;
        #1 chk("reset_outputs", {30'h0, bsy[0], dn[0], er[0], ce[0], oen[0], wen[0], bs[0], fa[0], dout[0]},
               {30'h0, 6'b000011, 8'h00, 12'h000, 8'h00});
        repeat (3) @(posedge m2);
        reset_pin = 1'b1;

        // Program + illegal command, cycle by cycle
        mode = 0;
        addr = 20'h34123; wdata = 8'h5A;
        for (int i = 0; i < 22; i++) begin
            @(posedge m2);
            act = {bsy[0], dn[0], er[0], ce[0], oen[0], wen[0], bs[0], fa[0], dout[0]};
            chk($sformatf("vec%0d", i), {30'h0, act}, {30'h0, tbl[i].fl, tbl[i].b, tbl[i].a, tbl[i].d});
            req = tbl[i].rq; cmd = tbl[i].c;
        end

        // Sector erase, completes on the 7th sample
        mode = 1;
        run_op(2'b01, 20'h7F0FF, 8'h00);
        chk("erase_latency", lat[0], 33);
        chk("erase_err", {63'h0, erv[0]}, 64'h0);
        chk("erase_nwr", wq[0].size(), 6);
        for (int i = 0; i < 6; i++) chk_wr(0, "erase_wr", i, ewr[i]);

        // Chip erase
        mode = 0;
        run_op(2'b10, 20'h12345, 8'h00);
        chk("chip_latency", lat[0], 23);
        chk_wr(0, "chip_wr", 5, {8'h05, 12'h555, 8'h10});

        // Program with timeout on the POLL_LIMIT=4 instance
        run_op(2'b00, 20'h34123, 8'h5A);
        chk("prog_latency", lat[0], 17);
        chk("prog_err", {63'h0, erv[0]}, 64'h0);
        chk("to_latency", lat[1], 24);
        chk("to_err", {63'h0, erv[1]}, 64'h1);
        chk("to_nwr", wq[1].size(), 5);
        chk_wr(1, "to_wr", 3, pwr[3]);
        chk_wr(1, "to_wr", 4, {8'h05, 12'h555, 8'hF0});

        // Illegal command
        run_op(2'b11, 20'h34123, 8'h5A);
        chk("ill_latency", lat[0], 1);
        chk("ill_err", {63'h0, erv[0]}, 64'h1);
        chk("ill_ce", {63'h0, ceseen[0]}, 64'h0);

        // Reset during the 3rd write pulse of an erase
        wait_idle();
        req = 1'b1; cmd = 2'b01; addr = 20'h7F0FF;
        np = 0;
        for (int cyc = 0; cyc < 50 && np < 3; cyc++) begin
            @(posedge m2);
            req = 1'b0;
            if (!wen[0]) np++;
        end
        chk("rst_pulse_found", np, 3);
        #2 reset_pin = 1'b0;
        #1 chk("rst_async", {58'h0, bsy[0], dn[0], er[0], ce[0], oen[0], wen[0]}, {58'h0, 6'b000011});
        sawdone = 1'b0;
        repeat (4) begin @(posedge m2); if (dn[0]) sawdone = 1'b1; end
        reset_pin = 1'b1;
        repeat (3) begin @(posedge m2); if (dn[0] || bsy[0]) sawdone = 1'b1; end
        chk("rst_no_done", {63'h0, sawdone}, 64'h0);
        run_op(2'b00, 20'h34123, 8'h5A);
        chk("post_rst_latency", lat[0], 17);
        chk("post_rst_err", {63'h0, erv[0]}, 64'h0);
        chk_wr(0, "post_rst_wr", 3, pwr[3]);

        // req held high: back-to-back programs with one DONE cycle between
        wait_idle();
        req = 1'b1; cmd = 2'b00; addr = 20'h34123; wdata = 8'h5A;
        c1 = 0; c2 = 0;
        for (int cyc = 1; cyc <= 100 && c2 == 0; cyc++) begin
            @(posedge m2);
            if (dn[0]) begin
                if (c1 == 0) c1 = cyc; else c2 = cyc;
            end
            if (c1 == cyc - 1 && c1 != 0)
                chk("b2b_restart", {56'h0, bsy[0], dn[0], er[0], ce[0], dout[0]}, {56'h0, 4'b1001, 8'hAA});
        end
        req = 1'b0;
        chk("b2b_first", c1, 17);
        chk("b2b_gap", c2 - c1, 17);
        wait_idle();

        chk("oe_we_exclusive", {63'h0, viol}, 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flash_prog_seq.md
FLASH_PROG_SEQ -- requirements
Module: flash_prog_seq

Interface
REQ-001 The block SHALL have parameter POLL_LIMIT, default 16'hFFFF: maximum number of status-poll samples before a timeout.
REQ-002 The block SHALL have port m2  input  1  system clock; all state updates on the falling edge.
REQ-003 The block SHALL have port reset_pin  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req  input  1  start request, sampled in IDLE only.
REQ-005 The block SHALL have port cmd  input  2  operation code: 00 program byte, 01 sector erase, 10 chip erase, 11 illegal.
REQ-006 The block SHALL have port addr  input  20  target flash address (bank = addr[19:12], offset = addr[11:0]), captured at accept.
REQ-007 The block SHALL have port wdata  input  8  program data, captured at accept.
REQ-008 The block SHALL have port busy  output  1  high from accept until the done cycle inclusive.
REQ-009 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port err  output  1  result flag, valid with done and held until the next accept.
REQ-011 The block SHALL have port flash_bs  output  8  flash bank-select bits.
REQ-012 The block SHALL have port flash_addr  output  12  flash offset bits.
REQ-013 The block SHALL have port flash_dout  output  8  data driven to flash.
REQ-014 The block SHALL have port flash_din  input  8  data read from flash.
REQ-015 The block SHALL have ports flash_ce (1, active-high), flash_oe_n (1, active-low) and flash_we_n (1, active-low) as flash strobes.

Function
REQ-016 States SHALL be: IDLE, W_SETUP, W_PULSE, W_HOLD, P_OE, P_SAMPLE, DONE.
REQ-017 In IDLE, req=1 with a legal cmd SHALL capture cmd/addr/wdata, clear err, zero the step and poll counters, and go to W_SETUP (accept edge k).
REQ-018 In IDLE, req=1 with cmd=11 SHALL go directly to DONE with err=1 and SHALL issue no bus cycle.
REQ-019 req SHALL be ignored in every state other than IDLE.
REQ-020 Each bus write SHALL take three cycles:
  - W_SETUP: ce=1, we_n=1, address/data valid.
  - W_PULSE: we_n=0.
  - W_HOLD: we_n=1, address/data unchanged.
REQ-021 Program SHALL issue 4 writes: (05,555)<-AA, (02,AAA)<-55, (05,555)<-A0, (addr)<-wdata.
REQ-022 Sector erase SHALL issue 6 writes: AA, 55, (05,555)<-80, AA, 55, then (addr[19:12],000)<-30.
REQ-023 Chip erase SHALL issue the same first 5 writes, then (05,555)<-10.
REQ-024 After the last W_HOLD the block SHALL enter P_OE, with ce=1, oe_n=0 and flash_bs/flash_addr = captured addr, then go to P_SAMPLE.
REQ-025 In P_SAMPLE (oe_n=0), the falling edge SHALL latch flash_din[6] and increment the poll counter.
REQ-026 Completion SHALL be declared when a sample's bit6 equals the previous sample's bit6; the first sample SHALL never complete.
REQ-027 On completion the block SHALL go to DONE with err=0; otherwise it SHALL return to P_OE.
REQ-028 When the poll counter reaches POLL_LIMIT without completion, the block SHALL issue one reset write (05,555)<-F0 (three cycles), then go to DONE with err=1.
REQ-029 Timing for a program where the flash finishes immediately SHALL be:
  - W_SETUP after edge k;
  - P_OE after edge k+12;
  - samples at edges k+14 and k+16;
  - done high in the cycle after edge k+16.
REQ-030 Erase timing SHALL be identical with 6 writes: done high in the cycle after edge k+22.
REQ-031 DONE SHALL last exactly one cycle with done=1, then go to IDLE; a new req can be accepted on the edge that leaves DONE.
REQ-032 Outside write/poll states the outputs SHALL be ce=0, oe_n=1, we_n=1, flash_dout=00, flash_bs=00, flash_addr=000.
REQ-033 oe_n and we_n SHALL never be low simultaneously.

Reset
REQ-034 reset_pin=0 SHALL immediately force IDLE and busy=0, done=0, err=0, ce=0, oe_n=1, we_n=1, flash_bs=00, flash_addr=000, flash_dout=00, regardless of the current state.
REQ-035 Reset during an operation SHALL abort it with no done pulse; the first accept after reset_pin=1 SHALL start a fresh sequence.

Verification
REQ-036 Program: cmd=00, addr=0x3_4123, wdata=5A, flash_din bit6 constant -> writes AA, 55, A0, then 5A at bs=34/addr=123; done in the cycle after edge k+16; err=0.
REQ-037 Sector erase: cmd=01, addr=0x7_F0FF, bit6 toggling for 5 samples then stable -> final write 30 at bs=7F/addr=000; done after the 7th sample; err=0.
REQ-038 Timeout: POLL_LIMIT=4, bit6 toggles on every sample -> F0 written at (05,555) after the 4th sample; done=1 with err=1.
REQ-039 Illegal command: cmd=11 -> done in the cycle after accept, err=1, ce stays 0 throughout.
REQ-040 Reset mid-erase: reset_pin=0 during the 3rd W_PULSE -> we_n=1 and busy=0 asynchronously; no done pulse; a subsequent program request completes normally.
REQ-041 req held high continuously: back-to-back operations with exactly one DONE cycle between them, and req ignored while busy.
